// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;
    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_BIT   = 1'b0;
    localparam logic STOP_BIT    = 1'b1;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-time generator: counts CLK cycles within a bit and data bits within a frame.
module uart_tx_bit_timer #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 5
) (
    input  logic                          CLK,
    input  logic                          Reset,
    input  logic                          enable,
    input  logic                          count_bits,
    input  logic [PRESCALE_WIDTH-1:0]     prescale,
    output logic                          last_edge,
    output logic [$clog2(DATA_WIDTH)-1:0] bit_count
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0]             LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_WIDTH-1:0] ONE      = PRESCALE_WIDTH'(1);

    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [PRESCALE_WIDTH-1:0] last_val;
    logic [BW-1:0]             bit_cnt;

    // A prescale of zero behaves as one cycle per bit.
    assign last_val  = (prescale == '0) ? '0 : prescale - ONE;
    assign last_edge = enable && (edge_cnt == last_val);
    assign bit_count = bit_cnt;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            edge_cnt <= '0;
        end else if (!enable || last_edge) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + ONE;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            bit_cnt <= '0;
        end else if (!count_bits) begin
            bit_cnt <= '0;
        end else if (last_edge) begin
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first payload, optional parity, stop bit on S_Data.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic [DATA_WIDTH-1:0]     P_Data,
    input  logic                      Data_valid,
    input  logic                      Parity_EN,
    input  logic                      Parity_type,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      S_Data,
    output logic                      Busy
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    tx_state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]     shreg_q, shreg_d;
    logic                      line_q, line_d;
    logic                      par_en_q, par_bit_q;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic                      accept;
    logic                      last_edge;
    logic [BW-1:0]             bit_count;

    uart_tx_bit_timer #(
        .DATA_WIDTH    (DATA_WIDTH),
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_timer (
        .CLK       (CLK),
        .Reset     (Reset),
        .enable    (state_q != IDLE),
        .count_bits(state_q == DATA),
        .prescale  (prescale_q),
        .last_edge (last_edge),
        .bit_count (bit_count)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            line_q     <= LINE_IDLE;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            prescale_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            line_q  <= line_d;
            if (accept) begin
                par_en_q   <= Parity_EN;
                par_bit_q  <= (^P_Data) ^ (Parity_type == PARITY_ODD);
                prescale_q <= Prescale;
            end
        end
    end

    // line_d is the level the line takes in the state being entered, so S_Data stays registered.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        line_d  = line_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                line_d = LINE_IDLE;
                if (Data_valid) begin
                    accept  = 1'b1;
                    shreg_d = P_Data;
                    state_d = START;
                    line_d  = START_BIT;
                end
            end
            START: begin
                if (last_edge) begin
                    state_d = DATA;
                    line_d  = shreg_q[0];
                end
            end
            DATA: begin
                if (last_edge) begin
                    if (bit_count == LAST_BIT) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            line_d  = par_bit_q;
                        end else begin
                            state_d = STOP;
                            line_d  = STOP_BIT;
                        end
                    end else begin
                        shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
                        line_d  = shreg_q[1];
                    end
                end
            end
            PARITY: begin
                if (last_edge) begin
                    state_d = STOP;
                    line_d  = STOP_BIT;
                end
            end
            STOP: begin
                if (last_edge) begin
                    state_d = IDLE;
                    line_d  = LINE_IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                line_d  = LINE_IDLE;
            end
        endcase
    end

    assign S_Data = line_q;
    assign Busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of frames plus back-to-back and mid-frame reset sequences.
module tb_uart_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] p_data;
    logic       data_valid;
    logic       parity_en;
    logic       parity_type;
    logic [4:0] prescale;
    logic       s_data;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  data;
        logic        par_en;
        logic        par_type;
        logic [4:0]  prescale;
        logic [10:0] bits;      // expected line levels, first transmitted bit at [10]
        int          nbits;
        int          busy_cycles;
        bit          disturb;   // inject 3C request and config change at cycle 20
    } vec_t;

    vec_t vecs[6];

    uart_tx dut (
        .CLK        (clk),
        .Reset      (rst_n),
        .P_Data     (p_data),
        .Data_valid (data_valid),
        .Parity_EN  (parity_en),
        .Parity_type(parity_type),
        .Prescale   (prescale),
        .S_Data     (s_data),
        .Busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_frame(input int id, input vec_t v);
        int   p;
        int   c;
        int   bi;
        logic exp_b;
        logic obs[11];
        bit   bad[11];
        p = (v.prescale == 0) ? 1 : int'(v.prescale);
        for (int b = 0; b < 11; b++) begin
            obs[b] = 1'bx;
            bad[b] = 1'b0;
        end
        @(negedge clk);
        p_data      = v.data;
        parity_en   = v.par_en;
        parity_type = v.par_type;
        prescale    = v.prescale;
        data_valid  = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        c = 0;
        while (busy === 1'b1 && c < 400) begin
            bi = c / p;
            if (bi < 11 && !bad[bi]) begin
                exp_b   = (bi < v.nbits) ? v.bits[10 - bi] : 1'b1;
                obs[bi] = s_data;
                if (s_data !== exp_b) bad[bi] = 1'b1;
            end
            if (v.disturb && c == 20) begin
                p_data      = 8'h3C;
                prescale    = 5'd4;
                parity_en   = ~v.par_en;
                parity_type = ~v.par_type;
                data_valid  = 1'b1;
            end
            if (v.disturb && c == 21) data_valid = 1'b0;
            @(negedge clk);
            c++;
        end
        check($sformatf("v%0d_busy_cycles", id), c, v.busy_cycles);
        for (int b = 0; b < v.nbits; b++)
            check($sformatf("v%0d_bit%0d", id, b), {31'd0, obs[b]}, {31'd0, v.bits[10 - b]});
        check($sformatf("v%0d_idle_line", id), {31'd0, s_data}, 32'd1);
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_no_queue", id), {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int   c;
        logic all_ok;

        //          data   en    typ   P      bits (time order)   n   busy dist
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 5'd8,  11'b01010010101, 11, 88,  1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 5'd8,  11'b01010010111, 11, 88,  1'b0};
        vecs[2] = '{8'hA5, 1'b0, 1'b0, 5'd8,  11'b01010010110, 10, 80,  1'b1};
        vecs[3] = '{8'h81, 1'b0, 1'b0, 5'd0,  11'b01000000110, 10, 10,  1'b0};
        vecs[4] = '{8'h81, 1'b0, 1'b0, 5'd31, 11'b01000000110, 10, 310, 1'b1};
        vecs[5] = '{8'h3C, 1'b1, 1'b1, 5'd3,  11'b00011110011, 11, 33,  1'b0};

        rst_n       = 1'b0;
        p_data      = 8'h00;
        data_valid  = 1'b0;
        parity_en   = 1'b0;
        parity_type = 1'b0;
        prescale    = 5'd8;
        repeat (3) @(negedge clk);
        check("reset_line", {31'd0, s_data}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_frame(i, vecs[i]);

        // Back-to-back: Data_valid held high, FF then 00, Prescale 5, no parity.
        @(negedge clk);
        p_data     = 8'hFF;
        parity_en  = 1'b0;
        prescale   = 5'd5;
        data_valid = 1'b1;
        @(negedge clk);
        p_data = 8'h00;
        c      = 0;
        all_ok = 1'b1;
        while (busy === 1'b1 && c < 200) begin
            if (c % 5 == 2 && c / 5 >= 1 && c / 5 <= 9 && s_data !== 1'b1) all_ok = 1'b0;
            if (c == 2 && s_data !== 1'b0) all_ok = 1'b0;
            @(negedge clk);
            c++;
        end
        check("b2b_ff_busy_cycles", c, 50);
        check("b2b_ff_frame", {31'd0, all_ok}, 32'd1);
        check("b2b_gap_busy", {31'd0, busy}, 32'd0);
        check("b2b_gap_line", {31'd0, s_data}, 32'd1);
        @(negedge clk);
        check("b2b_second_busy", {31'd0, busy}, 32'd1);
        check("b2b_second_start", {31'd0, s_data}, 32'd0);
        data_valid = 1'b0;
        c      = 0;
        all_ok = 1'b1;
        while (busy === 1'b1 && c < 200) begin
            if (c % 5 == 2 && c / 5 >= 1 && c / 5 <= 8 && s_data !== 1'b0) all_ok = 1'b0;
            if (c % 5 == 2 && c / 5 == 9 && s_data !== 1'b1) all_ok = 1'b0;
            @(negedge clk);
            c++;
        end
        check("b2b_00_busy_cycles", c, 50);
        check("b2b_00_frame", {31'd0, all_ok}, 32'd1);

        // Reset in the middle of data bit 3 of an A5 frame.
        repeat (2) @(negedge clk);
        p_data     = 8'hA5;
        parity_en  = 1'b0;
        prescale   = 5'd8;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (35) @(negedge clk);
        check("pre_reset_line", {31'd0, s_data}, 32'd0);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_line", {31'd0, s_data}, 32'd1);
        check("mid_reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_busy", {31'd0, busy}, 32'd0);
        check("post_reset_line", {31'd0, s_data}, 32'd1);
        run_frame(10, vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
